// File: rtl/dmn_pkg.sv
// Shared types and constants for dmn stage initiators.
package dmn_pkg;

  localparam int unsigned DMN_W       = 32;
  localparam logic [31:0] TIMEOUT_DEF = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2,
    ST_DONE = 2'd3
  } dmn_state_e;

endpackage

// File: rtl/dmn_tocnt.sv
// Saturating up-counter with synchronous clear and terminal-count flag at TIMEOUT-1.
module dmn_tocnt
  import dmn_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // TIMEOUT of zero never reaches terminal count; the counter just saturates.
  assign tc = (TIMEOUT != 32'd0) && (cnt == TC_VAL);

endmodule

// File: rtl/dmn_req.sv
// Initiator side of the dmn 4-phase handshake: request, capture stage results, release.
//
// state   | meaning
// IDLE    | waiting for start
// REQ     | dmn_en high, waiting for dmn_end
// REL     | dmn_en low, waiting for dmn_end to drop
// DONE    | one-cycle completion pulse
module dmn_req
  import dmn_pkg::*;
#(
  parameter logic [31:0] TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             dmn_en,
  input  logic             dmn_end,
  input  logic             dmn_zero,
  input  logic [DMN_W-1:0] dmn_para1,
  input  logic [DMN_W-1:0] dmn_para2,
  input  logic [DMN_W-1:0] dmn_para3,
  output logic             zero_q,
  output logic [DMN_W-1:0] para1_q,
  output logic [DMN_W-1:0] para2_q,
  output logic [DMN_W-1:0] para3_q,
  output logic [CNT_W-1:0] lat_q
);

  dmn_state_e       state;
  dmn_state_e       state_nxt;
  logic             cap_en;
  logic             set_err;
  logic             clr_err;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic             tc;

  dmn_tocnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_tocnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    set_err   = 1'b0;
    clr_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_REQ;
          clr_err   = 1'b1;
        end
      end
      ST_REQ: begin
        // An acknowledge on the terminal cycle still wins over the timeout.
        if (dmn_end) begin
          state_nxt = ST_REL;
          cap_en    = 1'b1;
        end else if (tc) begin
          state_nxt = ST_DONE;
          set_err   = 1'b1;
        end
      end
      ST_REL: begin
        if (!dmn_end) begin
          state_nxt = ST_DONE;
        end else if (tc) begin
          state_nxt = ST_DONE;
          set_err   = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Counter restarts from zero on every state change, so REQ and REL each get a full budget.
  assign cnt_clr = (state_nxt != state);
  assign cnt_en  = (state == ST_REQ) || (state == ST_REL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      dmn_en <= 1'b0;
    end else begin
      busy   <= (state_nxt != ST_IDLE);
      done   <= (state_nxt == ST_DONE);
      dmn_en <= (state_nxt == ST_REQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr_err) begin
      err <= 1'b0;
    end else if (set_err) begin
      err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      para1_q <= '0;
      para2_q <= '0;
      para3_q <= '0;
      lat_q   <= '0;
    end else if (cap_en) begin
      zero_q  <= dmn_zero;
      para1_q <= dmn_para1;
      para2_q <= dmn_para2;
      para3_q <= dmn_para3;
      lat_q   <= cnt;
    end
  end

endmodule

// File: doc/dmn_req.md
Name: dmn_req

Overview:
- Initiator side of the dmn stage handshake; a dmn stage is the responder.
- On a start pulse, raises dmn_en toward one dmn stage and waits for dmn_end.
- Captures the stage's zero flag and three 32-bit parameter words, then completes a 4-phase release and reports done or timeout to the upstream controller.
- Sits between the top-level sequencer and any dmn_* stage. Stages may tie dmn_end combinationally to dmn_en.

Parameters:
- TIMEOUT, 32'd1024: max cycles in REQ or REL before abort; 0 disables the timeout.
- CNT_W, 32: width of the cycle counter; must hold TIMEOUT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle request pulse from the sequencer
- busy  output  1  high from the accepted start until done
- done  output  1  1-cycle pulse at completion (success or error)
- err  output  1  sticky timeout flag; cleared on the next accepted start
- dmn_en  output  1  request to the stage
- dmn_end  input  1  acknowledge from the stage
- dmn_zero  input  1  stage zero flag
- dmn_para1  input  32  stage parameter word 1
- dmn_para2  input  32  stage parameter word 2
- dmn_para3  input  32  stage parameter word 3
- zero_q  output  1  captured zero flag
- para1_q  output  32  captured word 1
- para2_q  output  32  captured word 2
- para3_q  output  32  captured word 3
- lat_q  output  CNT_W  cycles from dmn_en rise to dmn_end sampled high

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Applies immediately and asynchronously, including mid-handshake; dmn_en drops with rst_n.
- State IDLE:
  - start=1 → REQ next edge; clears err and counter, sets busy, sets dmn_en.
  - start while not IDLE is ignored; no queueing.
- State REQ:
  - dmn_en=1; counter increments each cycle.
  - dmn_end sampled 1 → capture dmn_zero, para1..3 and lat_q=counter; dmn_en→0; counter→0; go to REL.
  - Combinational responder: dmn_end rises in the same cycle as dmn_en and is sampled at the first edge after REQ entry, so lat_q=0.
  - counter==TIMEOUT-1 with dmn_end still 0 (TIMEOUT≠0) → err=1, dmn_en→0, captured registers unchanged, go to DONE.
- State REL:
  - dmn_en=0; wait for dmn_end sampled 0, then go to DONE. A combinational responder takes exactly 1 cycle here.
  - counter reaches TIMEOUT-1 with dmn_end still 1 → err=1, go to DONE. Captured data is retained.
- State DONE: done=1 for this one cycle, busy→0 next edge, go to IDLE.
  - A start asserted during DONE is ignored; start is accepted only in IDLE.
- Total latency, start to done, for a combinational responder: start edge → REQ (1) → REL (1) → DONE (1). done is high in the 3rd cycle after the start edge.
- Captured outputs hold their value until the next successful capture.
- Counter saturates at its all-ones value and never wraps, including when TIMEOUT=0.
- Inputs are synchronous to clk; no synchronisers are required.

Decomposition:
- Shared package dmn_pkg:
  - state encoding typedef (IDLE, REQ, REL, DONE)
  - DMN_W=32 parameter-word width
  - default TIMEOUT constant
- Sub-module dmn_tocnt: saturating cycle counter with clear, enable and terminal-count compare against TIMEOUT. Reused by other dmn initiators.
- FSM, capture registers and output logic live in dmn_req.

Test Plan:
- Combinational responder (dmn_end=dmn_en, zero=0, para=32'hff9911/2/8): start pulse → done in the 3rd cycle after start; para1_q=32'hff9911, para2_q=2, para3_q=8, zero_q=0, lat_q=0, err=0.
- Responder asserting dmn_end 5 cycles after dmn_en, releasing 2 cycles after dmn_en falls: lat_q=5, done after REL, dmn_en high for exactly 6 cycles.
- dmn_end never asserts, TIMEOUT=16: dmn_en high 16 cycles, err=1, done pulse, para*_q keep prior values. Next start clears err.
- dmn_end stuck high after capture, TIMEOUT=16: capture occurs, err=1 after 16 REL cycles, captured data valid.
- start pulses during REQ, REL and DONE: ignored; exactly one done per accepted start.
- rst_n low mid-REQ: dmn_en, busy and all captured outputs 0 immediately; clean operation on the next start after reset release.
